cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Multicycle fetch/decode/sequencing controller that sits directly upstream of the CPU datapath.
- Fetches 32-bit instructions from a synchronous instruction memory, holds the current one in an instruction register, and drives every datapath control input: register addresses, immediate, ALU control, mux selects and write enable.
- Owns the 9-bit PC. Resolves branches from latched datapath flags and jump-register targets from rfRdData0Short.

Parameters:
- PC_W, 9, PC / instruction-memory address width.
- RESET_PC, 9'd0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rstN  in  1  asynchronous active-low reset.
- imemData  in  32  instruction word; valid the cycle after imemAdrx is presented.
- cFlag, nFlag, vFlag, zFlag  in  1 each  datapath ALU flags (combinational from the current ALU operation).
- rfRdData0Short  in  9  rdData0[8:0] from the datapath; used as the JR target.
- imemAdrx  out  9  instruction fetch address (= PC).
- immediate  out  16  instr[15:0].
- rfRdAdrx0  out  5  instr[21:17] (rs).
- rfRdAdrx1  out  5  instr[16:12] (rt) for R-type; instr[26:22] (rd) for SW.
- rfWrAdrx  out  5  instr[26:22] (rd).
- aluCtl  out  3  ALU operation.
- rfWriteEn  out  1  register-file write strobe.
- aluBusBSel  out  1  1 = immediate on bus B.
- dmemResultSel  out  1  1 = write-back from data memory.
- regDest  out  1  tied to 1 (write address always rfWrAdrx).
- dmemWrEn  out  1  data-memory write strobe.
- halted  out  1  high in the HALT state.

Behaviour:
- Instruction format: op = instr[31:27], rd = [26:22], rs = [21:17], rt = [16:12], imm = [15:0].
- Opcodes:
  - 00001..00111: R-type; aluCtl = op[2:0] (001 add, 010 sub, 011 and, 100 or, 101 xor, 110 slt, 111 sll).
  - 01001: ADDI.
  - 01010: LW, address = rs + imm.
  - 01011: SW, stores rd to rs + imm.
  - 10000: B.
  - 10001: BGT, taken when Z = 0 and N = V.
  - 10010: JR.
  - 11111: HALT.
  - All other opcodes, including 00000, are NOPs.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is free.
- Transitions:
  - FETCH -> DECODE: IR loads imemData on the DECODE edge.
  - DECODE -> EXEC, or -> HALT if op = HALT.
  - EXEC -> WB for R-type and ADDI.
  - EXEC -> MEM for LW and SW.
  - EXEC -> FETCH for branches, JR and NOP.
  - MEM -> WB for LW; MEM -> FETCH for SW.
  - WB -> FETCH.
  - HALT is absorbing until reset.
- Cycles per instruction:
  - R-type / ADDI: 4.
  - LW: 5.
  - SW: 4.
  - B / BGT / JR / NOP: 3.
- Control outputs are decoded combinationally from IR and are stable from DECODE through the last state of the instruction.
  - aluBusBSel = 1 for ADDI, LW, SW.
  - aluCtl = 001 for ADDI, LW, SW.
- Strobes:
  - rfWriteEn = 1 only in WB, for exactly one cycle.
  - dmemResultSel = 1 in MEM and WB of LW only.
  - dmemWrEn = 1 only in MEM of SW, for exactly one cycle.
- Flags: internal register {C, N, V, Z} loads the flag inputs at the end of EXEC for R-type and ADDI only. Its reset value is 0000. BGT evaluates the latched flags, never the live ones.
- PC update: at the end of EXEC.
  - B, or BGT taken: PC <= imm[8:0].
  - JR: PC <= rfRdData0Short.
  - Otherwise: PC <= PC + 1, modulo 512, so 511 wraps to 0.
  - HALT does not advance the PC.
- imemAdrx = PC at all times.
- Reset, asynchronous and allowed at any point mid-instruction:
  - state = FETCH, PC = RESET_PC, IR = 0 (NOP), flags = 0.
  - rfWriteEn, dmemWrEn, dmemResultSel, halted = 0.
  - No strobe may glitch high during reset.
  - After rstN deasserts, the first fetch is from RESET_PC.

Test Plan:
- Reset, then ADD r3 = r1 + r2 at PC 0 -> imemAdrx = 0; aluCtl = 001; rfRdAdrx0 = 1, rfRdAdrx1 = 2, rfWrAdrx = 3; rfWriteEn high exactly in cycle 4; PC = 1 afterwards.
- LW r5, 8(r1) followed by SW r5, 12(r1) -> LW: aluBusBSel = 1, immediate = 0x0008, dmemResultSel = 1 in cycles 4-5, rfWriteEn only in cycle 5. SW: dmemWrEn only in cycle 4, rfRdAdrx1 = 5, rfWriteEn never high.
- SUB giving flags Z=0, N=0, V=0, then BGT imm = 0x0040 -> PC = 64. Repeat with a SUB giving Z = 1 -> branch not taken, PC = branch PC + 1.
- PC at 511 executing NOP -> next imemAdrx = 0. B imm = 0x01FF -> PC = 511.
- JR with rfRdData0Short = 9'h123 -> next fetch address 0x123. HALT -> halted = 1, PC frozen for 20 cycles. Then rstN pulse -> PC = 0, halted = 0.
- rstN asserted during the MEM cycle of SW -> dmemWrEn drops immediately (asynchronously). After release, state restarts at FETCH with PC = 0 and no write-back occurs.

Source files
------------

// File: rtl/cpu_control_unit_if.sv
// Signal bundle between the control unit and its instruction memory / datapath.
// master = control unit, slave = memory + datapath side.
interface cpu_control_unit_if #(parameter int PC_W = 9);
  logic [31:0]     imemData;
  logic            cFlag, nFlag, vFlag, zFlag;
  logic [PC_W-1:0] rfRdData0Short;
  logic [PC_W-1:0] imemAdrx;
  logic [15:0]     immediate;
  logic [4:0]      rfRdAdrx0, rfRdAdrx1, rfWrAdrx;
  logic [2:0]      aluCtl;
  logic            rfWriteEn, aluBusBSel, dmemResultSel, regDest, dmemWrEn, halted;

  modport master (
    input  imemData, cFlag, nFlag, vFlag, zFlag, rfRdData0Short,
    output imemAdrx, immediate, rfRdAdrx0, rfRdAdrx1, rfWrAdrx, aluCtl,
           rfWriteEn, aluBusBSel, dmemResultSel, regDest, dmemWrEn, halted
  );

  modport slave (
    output imemData, cFlag, nFlag, vFlag, zFlag, rfRdData0Short,
    input  imemAdrx, immediate, rfRdAdrx0, rfRdAdrx1, rfWrAdrx, aluCtl,
           rfWriteEn, aluBusBSel, dmemResultSel, regDest, dmemWrEn, halted
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Multicycle fetch/decode/sequencing controller: owns PC, IR and latched ALU flags,
// and drives every datapath control from the current instruction and FSM state.
module cpu_control_unit #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rstN,
  cpu_control_unit_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [4:0] OP_ADDI = 5'b01001;
  localparam logic [4:0] OP_LW   = 5'b01010;
  localparam logic [4:0] OP_SW   = 5'b01011;
  localparam logic [4:0] OP_B    = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_JR   = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11111;

  state_t          state, nextState;
  logic [31:0]     ir;
  logic [PC_W-1:0] pc;
  logic            cF, nF, vF, zF;
  logic [4:0]      op;
  logic            isRType, isAddi, isLw, isSw, isB, isBgt, isJr, isHalt;
  logic            bgtTaken, writesFlags;
  logic            unusedCarry;

  assign op          = ir[31:27];
  assign isRType     = (op[4:3] == 2'b00) && (op[2:0] != 3'b000);
  assign isAddi      = (op == OP_ADDI);
  assign isLw        = (op == OP_LW);
  assign isSw        = (op == OP_SW);
  assign isB         = (op == OP_B);
  assign isBgt       = (op == OP_BGT);
  assign isJr        = (op == OP_JR);
  assign isHalt      = (op == OP_HALT);
  assign writesFlags = isRType || isAddi;
  assign bgtTaken    = !zF && (nF == vF);
  // Carry is architecturally latched but no current instruction consumes it.
  assign unusedCarry = cF;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= FETCH;
    else       state <= nextState;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ir <= '0;
      pc <= RESET_PC;
      {cF, nF, vF, zF} <= 4'b0000;
    end else begin
      if (state == FETCH) ir <= bus.imemData;
      if (state == EXEC) begin
        if (isB || (isBgt && bgtTaken)) pc <= ir[PC_W-1:0];
        else if (isJr)                  pc <= bus.rfRdData0Short;
        else                            pc <= pc + PC_W'(1);
        if (writesFlags) {cF, nF, vF, zF} <= {bus.cFlag, bus.nFlag, bus.vFlag, bus.zFlag};
      end
    end
  end

  // Strobes depend only on state (async-reset) and IR, so reset kills them at once.
  always_comb begin
    nextState         = state;
    bus.rfWriteEn     = 1'b0;
    bus.dmemWrEn      = 1'b0;
    bus.dmemResultSel = 1'b0;
    bus.halted        = 1'b0;
    unique case (state)
      FETCH:  nextState = DECODE;
      DECODE: nextState = isHalt ? HALT : EXEC;
      EXEC: begin
        if (writesFlags)      nextState = WB;
        else if (isLw || isSw) nextState = MEM;
        else                   nextState = FETCH;
      end
      MEM: begin
        nextState         = isLw ? WB : FETCH;
        bus.dmemWrEn      = isSw;
        bus.dmemResultSel = isLw;
      end
      WB: begin
        nextState         = FETCH;
        bus.rfWriteEn     = 1'b1;
        bus.dmemResultSel = isLw;
      end
      HALT: begin
        nextState  = HALT;
        bus.halted = 1'b1;
      end
      default: nextState = FETCH;
    endcase
  end

  always_comb begin
    bus.aluCtl     = 3'b000;
    bus.aluBusBSel = 1'b0;
    if (isRType) bus.aluCtl = op[2:0];
    if (isAddi || isLw || isSw) begin
      bus.aluCtl     = 3'b001;
      bus.aluBusBSel = 1'b1;
    end
  end

  assign bus.imemAdrx  = pc;
  assign bus.immediate = ir[15:0];
  assign bus.rfRdAdrx0 = ir[21:17];
  assign bus.rfRdAdrx1 = isSw ? ir[26:22] : ir[16:12];
  assign bus.rfWrAdrx  = ir[26:22];
  assign bus.regDest   = 1'b1;
endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: instruction-level reference model checked
// every cycle, plus literal expectations at hand-picked cycles.
module tb_cpu_control_unit;
  localparam logic [4:0] ADD = 5'd1, SUB = 5'd2, ADDI = 5'd9, LW = 5'd10, SW = 5'd11;
  localparam logic [4:0] B = 5'd16, BGT = 5'd17, JR = 5'd18, HLT = 5'd31;

  logic clk, rstN;
  cpu_control_unit_if ifc();
  cpu_control_unit dut (.clk(clk), .rstN(rstN), .bus(ifc));

  logic [31:0] mem [0:511];
  assign ifc.imemData = mem[ifc.imemAdrx];

  int errors = 0, checks = 0;
  int cyc = 0;

  // Instruction-level model: which cycle of which instruction we are in.
  bit          modelOn = 0;
  int          mPhase;
  logic [8:0]  mPc, mNextPc;
  logic [31:0] mInstr;
  logic [3:0]  mFlags;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkV(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic isR(input logic [4:0] o);
    return (o >= 5'd1) && (o <= 5'd7);
  endfunction

  function automatic int cpiOf(input logic [4:0] o);
    if (isR(o) || o == ADDI || o == SW) return 4;
    if (o == LW) return 5;
    return 3;
  endfunction

  function automatic logic [31:0] rEnc(input logic [4:0] o, input logic [4:0] rd, rs, rt);
    return {o, rd, rs, rt, 12'h000};
  endfunction

  function automatic logic [31:0] iEnc(input logic [4:0] o, input logic [4:0] rd, rs,
                                       input logic [15:0] imm);
    return {o, rd, rs, 1'b0, imm};
  endfunction

  // Model advance: fetch captures the word, execute resolves the next PC and flags.
  always @(posedge clk) if (modelOn) begin : mdl
    logic [4:0] o;
    o = mInstr[31:27];
    cyc++;
    if (mPhase == 1) begin
      mInstr = mem[mPc];
      mPhase = 2;
    end else if (mPhase == 2) begin
      mPhase = 3;
    end else if (o != HLT) begin
      if (mPhase == 3) begin
        if (o == B || (o == BGT && !mFlags[0] && mFlags[2] == mFlags[1])) mNextPc = mInstr[8:0];
        else if (o == JR) mNextPc = ifc.rfRdData0Short;
        else              mNextPc = mPc + 9'd1;
        if (isR(o) || o == ADDI) mFlags = {ifc.cFlag, ifc.nFlag, ifc.vFlag, ifc.zFlag};
      end
      if (mPhase == cpiOf(o)) begin
        mPc    = mNextPc;
        mPhase = 1;
      end else mPhase++;
    end
  end

  always @(negedge clk) if (modelOn) begin : cmp
    logic [4:0] o;
    int ph;
    o  = mInstr[31:27];
    ph = mPhase;
    chkV("imemAdrx", 32'(ifc.imemAdrx), 32'((ph >= 4) ? mNextPc : mPc));
    chk1("rfWriteEn", ifc.rfWriteEn,
         ((isR(o) || o == ADDI) && ph == 4) || (o == LW && ph == 5));
    chk1("dmemResultSel", ifc.dmemResultSel, o == LW && ph >= 4);
    chk1("dmemWrEn", ifc.dmemWrEn, o == SW && ph == 4);
    chk1("halted", ifc.halted, o == HLT && ph >= 3);
    chk1("regDest", ifc.regDest, 1'b1);
    if (ph >= 2) begin
      chkV("immediate", 32'(ifc.immediate), 32'(mInstr[15:0]));
      chkV("rfRdAdrx0", 32'(ifc.rfRdAdrx0), 32'(mInstr[21:17]));
      chkV("rfWrAdrx", 32'(ifc.rfWrAdrx), 32'(mInstr[26:22]));
      chk1("aluBusBSel", ifc.aluBusBSel, o == ADDI || o == LW || o == SW);
      if (isR(o)) begin
        chkV("aluCtlR", 32'(ifc.aluCtl), 32'(o[2:0]));
        chkV("rfRdAdrx1R", 32'(ifc.rfRdAdrx1), 32'(mInstr[16:12]));
      end
      if (o == SW) chkV("rfRdAdrx1SW", 32'(ifc.rfRdAdrx1), 32'(mInstr[26:22]));
      if (o == ADDI || o == LW || o == SW) chkV("aluCtlI", 32'(ifc.aluCtl), 32'd1);
    end
  end

  task automatic clearMem();
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
  endtask

  task automatic chkQuiet(input string tag);
    chk1({tag, "_rfWriteEn"}, ifc.rfWriteEn, 1'b0);
    chk1({tag, "_dmemWrEn"}, ifc.dmemWrEn, 1'b0);
    chk1({tag, "_dmemResultSel"}, ifc.dmemResultSel, 1'b0);
    chk1({tag, "_halted"}, ifc.halted, 1'b0);
    chkV({tag, "_imemAdrx"}, 32'(ifc.imemAdrx), 32'd0);
  endtask

  task automatic doReset();
    modelOn = 0;
    rstN    = 0;
    #1 chkQuiet("rst");
    repeat (2) begin
      @(negedge clk);
      chkQuiet("rstHold");
    end
    @(posedge clk);
    #1 rstN = 1;
    mPc = 9'd0; mNextPc = 9'd0; mInstr = 32'h0; mFlags = 4'h0; mPhase = 1;
    cyc = 1;
    modelOn = 1;
  endtask

  // Park at negedge+1 of cycle k (cycle 1 = first FETCH after reset release).
  task automatic toCycle(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rstN = 0;
    {ifc.cFlag, ifc.nFlag, ifc.vFlag, ifc.zFlag} = 4'b0000;
    ifc.rfRdData0Short = 9'h0;
    clearMem();

    // ADD r3 = r1 + r2
    mem[0] = rEnc(ADD, 5'd3, 5'd1, 5'd2);
    doReset();
    toCycle(1); chkV("add_adr", 32'(ifc.imemAdrx), 32'd0);
    toCycle(2);
    chkV("add_aluCtl", 32'(ifc.aluCtl), 32'd1);
    chkV("add_rs", 32'(ifc.rfRdAdrx0), 32'd1);
    chkV("add_rt", 32'(ifc.rfRdAdrx1), 32'd2);
    chkV("add_rd", 32'(ifc.rfWrAdrx), 32'd3);
    chk1("add_we2", ifc.rfWriteEn, 1'b0);
    toCycle(3); chk1("add_we3", ifc.rfWriteEn, 1'b0);
    toCycle(4); chk1("add_we4", ifc.rfWriteEn, 1'b1);
    toCycle(5);
    chk1("add_we5", ifc.rfWriteEn, 1'b0);
    chkV("add_pc", 32'(ifc.imemAdrx), 32'd1);
    toCycle(10);

    // LW r5,8(r1); SW r5,12(r1); reset lands in the SW MEM cycle
    clearMem();
    mem[0] = iEnc(LW, 5'd5, 5'd1, 16'h0008);
    mem[1] = iEnc(SW, 5'd5, 5'd1, 16'h000C);
    doReset();
    toCycle(2);
    chk1("lw_bsel", ifc.aluBusBSel, 1'b1);
    chkV("lw_imm", 32'(ifc.immediate), 32'h8);
    toCycle(4);
    chk1("lw_res4", ifc.dmemResultSel, 1'b1);
    chk1("lw_we4", ifc.rfWriteEn, 1'b0);
    toCycle(5);
    chk1("lw_res5", ifc.dmemResultSel, 1'b1);
    chk1("lw_we5", ifc.rfWriteEn, 1'b1);
    toCycle(7);
    chkV("sw_rt", 32'(ifc.rfRdAdrx1), 32'd5);
    chk1("sw_wr7", ifc.dmemWrEn, 1'b0);
    toCycle(9);
    chk1("sw_wr9", ifc.dmemWrEn, 1'b1);
    chk1("sw_we9", ifc.rfWriteEn, 1'b0);
    #1 modelOn = 0;
    rstN = 0;
    #1 chkQuiet("swRst");
    doReset();
    toCycle(1); chkV("swRst_adr", 32'(ifc.imemAdrx), 32'd0);
    toCycle(4); chk1("swRst_we", ifc.rfWriteEn, 1'b0);
    toCycle(6);

    // SUB (Z=0,N=0,V=0) then BGT 0x40; live Z goes high before BGT executes
    clearMem();
    mem[0] = rEnc(SUB, 5'd4, 5'd1, 5'd2);
    mem[1] = iEnc(BGT, 5'd0, 5'd0, 16'h0040);
    doReset();
    toCycle(5); ifc.zFlag = 1'b1;
    toCycle(8); chkV("bgt_taken", 32'(ifc.imemAdrx), 32'd64);
    toCycle(10);
    // Same program, SUB now gives Z=1 -> not taken
    doReset();
    toCycle(8); chkV("bgt_not", 32'(ifc.imemAdrx), 32'd2);
    toCycle(10);
    ifc.zFlag = 1'b0;

    // B to 511, NOP at 511 wraps to 0
    clearMem();
    mem[0] = iEnc(B, 5'd0, 5'd0, 16'h01FF);
    doReset();
    toCycle(4); chkV("b_511", 32'(ifc.imemAdrx), 32'd511);
    toCycle(7); chkV("wrap_0", 32'(ifc.imemAdrx), 32'd0);
    toCycle(9);

    // JR to 0x123, HALT there
    clearMem();
    mem[0] = iEnc(JR, 5'd0, 5'd7, 16'h0000);
    mem[9'h123] = {HLT, 27'h0};
    ifc.rfRdData0Short = 9'h123;
    doReset();
    toCycle(4);
    chkV("jr_adr", 32'(ifc.imemAdrx), 32'h123);
    chk1("jr_halt4", ifc.halted, 1'b0);
    toCycle(6); chk1("halt_on", ifc.halted, 1'b1);
    toCycle(26);
    chk1("halt_hold", ifc.halted, 1'b1);
    chkV("halt_pc", 32'(ifc.imemAdrx), 32'h123);
    doReset();
    toCycle(1);
    chk1("post_halt", ifc.halted, 1'b0);
    chkV("post_adr", 32'(ifc.imemAdrx), 32'd0);
    toCycle(3);

    modelOn = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
